// File: rtl/led_display_package.sv
// rtl/led_display_package.sv - shared constants, state type and pixel helper for the LED display driver
package led_display_package;

    localparam int GL_NUM_COLS      = 64;
    localparam int GL_NUM_ADDR_ROWS = 16;
    localparam int GL_COLOR_DEPTH   = 4;

    // Upper bound on one colour field (NUM_COLS*COLOR_DEPTH) accepted by field_pixel_bit
    localparam int GL_MAX_FIELD_W = 4096;
    localparam int GL_IDX_W       = 12;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } drv_state_t;

    function automatic logic field_pixel_bit(
        input logic [GL_MAX_FIELD_W-1:0] field,
        input int                        col,
        input int                        depth,
        input int                        plane
    );
        logic [GL_IDX_W-1:0] idx;
        idx = GL_IDX_W'(col * depth + plane);
        return field[idx];
    endfunction

endpackage

// File: rtl/led_display_bit_clk_gen.sv
// rtl/led_display_bit_clk_gen.sv - divided panel shift clock with data-advance and bit-end pulses
module led_display_bit_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic en,
    output logic bit_clk,
    output logic fall_tick,
    output logic bit_done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             clk_next;
    logic             active;

    // en describes the coming cycle, so bit_clk is registered in step with the state
    always_comb begin
        div_next = '0;
        clk_next = 1'b0;
        if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_next = '0;
                clk_next = ~bit_clk;
            end else begin
                div_next = div_cnt + 1'b1;
                clk_next = bit_clk;
            end
        end
    end

    assign fall_tick = en && (div_next == '0) && !clk_next;
    assign bit_done  = active && bit_clk && (div_cnt == DIV_LAST);

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            div_cnt <= '0;
            bit_clk <= 1'b0;
            active  <= 1'b0;
        end else if (en) begin
            div_cnt <= div_next;
            bit_clk <= clk_next;
            active  <= 1'b1;
        end else begin
            div_cnt <= '0;
            bit_clk <= 1'b0;
            active  <= 1'b0;
        end
    end

endmodule

// File: rtl/led_display_driver_bcm.sv
// rtl/led_display_driver_bcm.sv - HUB75 row driver shifting bit planes with binary-coded-modulation OE timing
module led_display_driver_bcm
    import led_display_package::*;
#(
    parameter int NUM_COLS       = GL_NUM_COLS,
    parameter int NUM_ADDR_ROWS  = GL_NUM_ADDR_ROWS,
    parameter int COLOR_DEPTH    = GL_COLOR_DEPTH,
    parameter int CLK_DIV        = 2,
    parameter int BASE_OE_CYCLES = 8,
    localparam int ADDR_W = (NUM_ADDR_ROWS > 1) ? $clog2(NUM_ADDR_ROWS) : 1,
    localparam int ROW_W  = 3 * NUM_COLS * COLOR_DEPTH
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              row_valid_in,
    input  logic [ROW_W-1:0]  row_top_in,
    input  logic [ROW_W-1:0]  row_bot_in,
    output logic              row_ready_out,
    output logic [ADDR_W-1:0] row_addr_out,
    output logic              frame_start_out,
    output logic              red_top_out,
    output logic              green_top_out,
    output logic              blue_top_out,
    output logic              red_bot_out,
    output logic              green_bot_out,
    output logic              blue_bot_out,
    output logic              bit_clk_out,
    output logic              latch_out,
    output logic              n_oe_out,
    output logic [ADDR_W-1:0] addr_out
);

    localparam int FW      = NUM_COLS * COLOR_DEPTH;
    localparam int COL_W   = $clog2(NUM_COLS + 1);
    localparam int PLANE_W = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam int OE_W    = $clog2(BASE_OE_CYCLES + 1) + COLOR_DEPTH;
    localparam int LAT_W   = $clog2(2 * CLK_DIV + 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(COLOR_DEPTH - 1);

    drv_state_t        state, state_next;
    logic [PLANE_W-1:0] plane, plane_sel;
    logic [COL_W-1:0]   col_cnt, col_sel;
    logic [LAT_W-1:0]   lat_cnt;
    logic [OE_W-1:0]    oe_cnt;
    logic [ROW_W-1:0]   top_sh, bot_sh, src_top, src_bot;
    logic [ADDR_W-1:0]  cap_addr;
    logic [5:0]         pix;
    logic               accept, fall_tick, bit_done;

    assign accept = row_valid_in && row_ready_out;

    led_display_bit_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_clk_gen (
        .clk_in    (clk_in),
        .n_reset_in(n_reset_in),
        .en        (state_next == SHIFT),
        .bit_clk   (bit_clk_out),
        .fall_tick (fall_tick),
        .bit_done  (bit_done)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (bit_done && col_cnt == '0) state_next = BLANK;
            BLANK:   state_next = LATCH;
            LATCH:   if (lat_cnt == '0) state_next = DISPLAY;
            DISPLAY: if (oe_cnt == '0) state_next = (plane == PLANE_LAST) ? IDLE : SHIFT;
            default: state_next = IDLE;
        endcase
    end

    // The first bit of a plane is loaded on the edge entering SHIFT, before the
    // shadow registers / plane counter have caught up, so look one step ahead.
    always_comb begin
        src_top   = (state == IDLE) ? row_top_in : top_sh;
        src_bot   = (state == IDLE) ? row_bot_in : bot_sh;
        plane_sel = plane;
        if (state == IDLE)
            plane_sel = '0;
        else if (state == DISPLAY)
            plane_sel = plane + 1'b1;
        col_sel = (state == SHIFT) ? col_cnt - 1'b1 : COL_W'(NUM_COLS - 1);
        pix[5] = field_pixel_bit(GL_MAX_FIELD_W'(src_top[3*FW-1:2*FW]), 32'(col_sel), COLOR_DEPTH, 32'(plane_sel));
        pix[4] = field_pixel_bit(GL_MAX_FIELD_W'(src_top[2*FW-1:FW]),   32'(col_sel), COLOR_DEPTH, 32'(plane_sel));
        pix[3] = field_pixel_bit(GL_MAX_FIELD_W'(src_top[FW-1:0]),      32'(col_sel), COLOR_DEPTH, 32'(plane_sel));
        pix[2] = field_pixel_bit(GL_MAX_FIELD_W'(src_bot[3*FW-1:2*FW]), 32'(col_sel), COLOR_DEPTH, 32'(plane_sel));
        pix[1] = field_pixel_bit(GL_MAX_FIELD_W'(src_bot[2*FW-1:FW]),   32'(col_sel), COLOR_DEPTH, 32'(plane_sel));
        pix[0] = field_pixel_bit(GL_MAX_FIELD_W'(src_bot[FW-1:0]),      32'(col_sel), COLOR_DEPTH, 32'(plane_sel));
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state           <= IDLE;
            plane           <= '0;
            col_cnt         <= '0;
            lat_cnt         <= '0;
            oe_cnt          <= '0;
            top_sh          <= '0;
            bot_sh          <= '0;
            cap_addr        <= '0;
            row_ready_out   <= 1'b1;
            row_addr_out    <= '0;
            frame_start_out <= 1'b0;
            latch_out       <= 1'b0;
            n_oe_out        <= 1'b1;
            addr_out        <= '0;
            {red_top_out, green_top_out, blue_top_out,
             red_bot_out, green_bot_out, blue_bot_out} <= '0;
        end else begin
            state           <= state_next;
            row_ready_out   <= (state_next == IDLE);
            latch_out       <= (state_next == LATCH);
            n_oe_out        <= (state_next != DISPLAY);
            frame_start_out <= accept && (row_addr_out == '0);

            if (accept) begin
                top_sh       <= row_top_in;
                bot_sh       <= row_bot_in;
                cap_addr     <= row_addr_out;
                plane        <= '0;
                row_addr_out <= (row_addr_out == ADDR_W'(NUM_ADDR_ROWS - 1)) ? '0 : row_addr_out + 1'b1;
            end

            if (fall_tick) begin
                col_cnt <= col_sel;
                {red_top_out, green_top_out, blue_top_out,
                 red_bot_out, green_bot_out, blue_bot_out} <= pix;
            end

            if (state == SHIFT && state_next == BLANK && plane == '0)
                addr_out <= cap_addr;

            if (state == BLANK)
                lat_cnt <= LAT_W'(2 * CLK_DIV - 1);
            else if (state == LATCH)
                lat_cnt <= lat_cnt - 1'b1;

            // Plane p is lit for BASE_OE_CYCLES << p cycles
            if (state == LATCH)
                oe_cnt <= (OE_W'(BASE_OE_CYCLES) << plane) - 1'b1;
            else if (state == DISPLAY)
                oe_cnt <= oe_cnt - 1'b1;

            if (state == DISPLAY && state_next == SHIFT)
                plane <= plane + 1'b1;
        end
    end

endmodule

// File: tb/tb_led_display_driver_bcm.sv
// tb/tb_led_display_driver_bcm.sv - scoreboard bench for led_display_driver_bcm
module tb_led_display_driver_bcm;

    localparam int NC = 8, NR = 4, CD = 2, CDIV = 1, BOE = 4;

    logic        clk_in = 1'b0;
    logic        n_reset_in, row_valid_in;
    logic [47:0] row_top_in, row_bot_in;
    logic        row_ready_out, frame_start_out;
    logic [1:0]  row_addr_out, addr_out;
    logic        red_top_out, green_top_out, blue_top_out;
    logic        red_bot_out, green_bot_out, blue_bot_out;
    logic        bit_clk_out, latch_out, n_oe_out;

    always #5 clk_in = ~clk_in;

    led_display_driver_bcm #(
        .NUM_COLS(NC), .NUM_ADDR_ROWS(NR), .COLOR_DEPTH(CD),
        .CLK_DIV(CDIV), .BASE_OE_CYCLES(BOE)
    ) dut (
        .clk_in(clk_in), .n_reset_in(n_reset_in),
        .row_valid_in(row_valid_in), .row_top_in(row_top_in), .row_bot_in(row_bot_in),
        .row_ready_out(row_ready_out), .row_addr_out(row_addr_out),
        .frame_start_out(frame_start_out),
        .red_top_out(red_top_out), .green_top_out(green_top_out), .blue_top_out(blue_top_out),
        .red_bot_out(red_bot_out), .green_bot_out(green_bot_out), .blue_bot_out(blue_bot_out),
        .bit_clk_out(bit_clk_out), .latch_out(latch_out), .n_oe_out(n_oe_out),
        .addr_out(addr_out)
    );

    int checks = 0, errors = 0, cyc = 0;
    bit mon_en = 1'b0;

    logic [5:0] q_data[$];
    logic [1:0] q_addr[$];
    logic       q_fs[$];
    int         q_oe[$];
    int         q_lat[$];

    // Rows as {red, green, blue}; expected serial bytes have bit c = column c
    logic [47:0] top_tab [5] = '{48'hE4E4_FFFF_0000, 48'h0001_8000_00C0, 48'h0,
                                 48'h5555_0000_0000, 48'hE4E4_FFFF_0000};
    logic [47:0] bot_tab [5] = '{48'h0000_5555_AAAA, 48'h3000_0004_FFFF, 48'h0000_0000_0008,
                                 48'h0, 48'h0000_5555_AAAA};
    // exp_tab[row][plane][rt,gt,bt,rb,gb,bb]
    logic [7:0] exp_tab [5][2][6] = '{
        '{'{8'hAA, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00}, '{8'hCC, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF}},
        '{'{8'h01, 8'h00, 8'h08, 8'h40, 8'h02, 8'hFF}, '{8'h00, 8'h80, 8'h08, 8'h40, 8'h00, 8'hFF}},
        '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02}},
        '{'{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}},
        '{'{8'hAA, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00}, '{8'hCC, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF}}
    };

    // cycle offsets after acceptance and expected {ready, bit_clk, latch, n_oe}
    int         tr_k [15] = '{1, 2, 16, 17, 18, 19, 20, 23, 24, 25, 39, 40, 41, 42, 43};
    logic [3:0] tr_v [15] = '{4'b0001, 4'b0101, 4'b0101, 4'b0001, 4'b0011, 4'b0011, 4'b0000,
                              4'b0000, 4'b0001, 4'b0101, 4'b0101, 4'b0001, 4'b0011, 4'b0011, 4'b0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic present(input int idx, input logic [1:0] addr, input bit push);
        logic [5:0] e;
        row_top_in   = top_tab[idx];
        row_bot_in   = bot_tab[idx];
        row_valid_in = 1'b1;
        if (push) begin
            for (int p = 0; p < 2; p++) begin
                for (int c = 7; c >= 0; c--) begin
                    for (int k = 0; k < 6; k++) e[5-k] = exp_tab[idx][p][k][c];
                    q_data.push_back(e);
                end
                q_addr.push_back(addr);
                q_lat.push_back(2 * CDIV);
                q_oe.push_back(BOE << p);
            end
            q_fs.push_back(addr == 2'd0);
        end
    endtask

    task automatic await_accept(output int t);
        int g = 0;
        while (!row_ready_out && g < 300) begin
            tick();
            g++;
        end
        if (!row_ready_out) chk("accept_timeout", 32'd0, 32'd1);
        t = cyc;
        tick();
        row_valid_in = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!row_ready_out && g < 300) begin
            tick();
            g++;
        end
        if (!row_ready_out) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    logic       p_bclk = 1'b0, p_noe = 1'b1, p_lat = 1'b0, p_rdy = 1'b1;
    logic [1:0] p_addr = 2'd0, addr_fall = 2'd0;
    int         noe_run = 0, lat_run = 0;

    always @(negedge clk_in) begin
        if (mon_en && n_reset_in) begin
            if (bit_clk_out && !p_bclk) begin
                if (q_data.size() == 0) chk("data_unexpected", 32'd1, 32'd0);
                else chk("shift_data", {26'd0, red_top_out, green_top_out, blue_top_out,
                                        red_bot_out, green_bot_out, blue_bot_out}, q_data.pop_front());
            end
            if (!n_oe_out && p_noe) begin
                noe_run   = 1;
                addr_fall = addr_out;
                if (q_addr.size() == 0) chk("addr_unexpected", 32'd1, 32'd0);
                else chk("disp_addr", addr_out, q_addr.pop_front());
            end else if (!n_oe_out) begin
                noe_run++;
            end else if (!p_noe) begin
                if (q_oe.size() == 0) chk("oe_unexpected", 32'd1, 32'd0);
                else chk("oe_len", noe_run, q_oe.pop_front());
                chk("addr_stable", p_addr, addr_fall);
            end
            if (latch_out && !p_lat) lat_run = 1;
            else if (latch_out) lat_run++;
            else if (p_lat) begin
                if (q_lat.size() == 0) chk("latch_unexpected", 32'd1, 32'd0);
                else chk("latch_len", lat_run, q_lat.pop_front());
            end
            if (!row_ready_out && p_rdy) begin
                if (q_fs.size() == 0) chk("accept_unexpected", 32'd1, 32'd0);
                else chk("frame_start", frame_start_out, q_fs.pop_front());
            end else if (frame_start_out) begin
                chk("frame_start_spurious", 32'd1, 32'd0);
            end
        end
        p_bclk = bit_clk_out;
        p_noe  = n_oe_out;
        p_lat  = latch_out;
        p_rdy  = row_ready_out;
        p_addr = addr_out;
    end

    initial begin
        int t0, t1, tr;
        n_reset_in   = 1'b0;
        row_valid_in = 1'b0;
        row_top_in   = '0;
        row_bot_in   = '0;
        repeat (3) tick();
        n_reset_in = 1'b1;
        tick();
        mon_en = 1'b1;
        chk("rst_ready", row_ready_out, 1);
        chk("rst_n_oe", n_oe_out, 1);
        chk("rst_addr", addr_out, 0);
        chk("rst_bit_clk", bit_clk_out, 0);
        chk("rst_latch", latch_out, 0);
        chk("rst_row_addr", row_addr_out, 0);
        chk("rst_frame_start", frame_start_out, 0);

        present(0, 2'd0, 1'b1);
        await_accept(t0);
        for (int i = 0; i < 15; i++) begin
            wait_to(t0 + tr_k[i]);
            chk($sformatf("trace_T+%0d", tr_k[i]), {row_ready_out, bit_clk_out, latch_out, n_oe_out}, tr_v[i]);
        end

        // next row offered during the last DISPLAY: must wait for IDLE
        wait_to(t0 + 44);
        chk("hold_data_disp", {red_top_out, green_top_out, blue_top_out,
                               red_bot_out, green_bot_out, blue_bot_out}, 6'b010001);
        present(1, 2'd1, 1'b1);
        wait_to(t0 + 50);
        chk("trace_T+50", {row_ready_out, bit_clk_out, latch_out, n_oe_out}, 4'b0000);
        wait_to(t0 + 51);
        chk("trace_T+51", {row_ready_out, bit_clk_out, latch_out, n_oe_out}, 4'b1001);
        chk("hold_data_idle", {red_top_out, green_top_out, blue_top_out,
                               red_bot_out, green_bot_out, blue_bot_out}, 6'b010001);
        await_accept(t1);
        chk("accept_cycle", t1 - t0, 51);

        for (int i = 2; i < 5; i++) begin
            present(i, 2'(i % NR), 1'b1);
            await_accept(t1);
        end
        wait_ready();
        chk("row_addr_after5", row_addr_out, 1);

        // asynchronous reset in the middle of plane 1 shifting
        mon_en = 1'b0;
        present(1, 2'd1, 1'b0);
        await_accept(tr);
        wait_to(tr + 31);
        chk("pre_reset_bit_clk", bit_clk_out, 1);
        #2;
        n_reset_in = 1'b0;
        #1;
        chk("async_n_oe", n_oe_out, 1);
        chk("async_bit_clk", bit_clk_out, 0);
        chk("async_latch", latch_out, 0);
        chk("async_ready", row_ready_out, 1);
        chk("async_row_addr", row_addr_out, 0);
        q_data.delete();
        q_addr.delete();
        q_fs.delete();
        q_oe.delete();
        q_lat.delete();
        repeat (2) tick();
        n_reset_in = 1'b1;
        tick();
        mon_en = 1'b1;

        present(1, 2'd0, 1'b1);
        await_accept(t1);
        wait_ready();
        repeat (3) tick();

        chk("q_data_empty", q_data.size(), 0);
        chk("q_addr_empty", q_addr.size(), 0);
        chk("q_oe_empty", q_oe.size(), 0);
        chk("q_lat_empty", q_lat.size(), 0);
        chk("q_fs_empty", q_fs.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
